// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the response mux: transfer types, response codes,
// default-slave FSM states and the clamped select-index width helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  function automatic int sel_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for unmapped transfers, outputs registered-state only.
// Optional watchdog (AHB_RESP_MUX_TIMEOUT_EN) aborts a slave stalling TIMEOUT_CYCLES cycles.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic hclk,
  input  logic hreset,
  input  logic i_hready,
  input  logic i_unmapped,
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  input  logic i_slave_wait,
  output logic o_timeout,
`endif
  output logic o_active,
  output logic o_hready,
  output logic o_hresp
);

  ds_state_t r_state;
  ds_state_t w_state_nxt;
  logic      w_fire;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (i_hready) begin
        r_cnt <= '0;
      end else if (i_slave_wait) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_timeout <= w_fire;
    end
  end

  // Abort on the last permitted wait cycle so ERR1 follows immediately.
  assign w_fire    = (r_state == DS_IDLE) && i_slave_wait &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout = r_timeout;
`else
  assign w_fire = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= DS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DS_IDLE: if ((i_hready && i_unmapped) || w_fire) w_state_nxt = DS_ERR1;
      DS_ERR1: w_state_nxt = DS_ERR2;
      DS_ERR2: w_state_nxt = (i_hready && i_unmapped) ? DS_ERR1 : DS_IDLE;
      default: w_state_nxt = DS_IDLE;
    endcase
  end

  // Outputs depend on state only, keeping the bus HREADY path loop-free.
  assign o_active = (r_state != DS_IDLE);
  assign o_hready = (r_state != DS_ERR1);
  assign o_hresp  = (r_state != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response mux; data-phase select latched on HREADY, 0-cycle routing.
// Selected slave's HREADYOUT stalls the bus; optional watchdog via AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [NUM_SLAVES-1:0]            hsel,
  input  logic [1:0]                       htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]            hready_s,
  input  logic [NUM_SLAVES-1:0]            hresp_s,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic                             hresp
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  ,
  output logic                             timeout
`endif
);

  localparam int IDX_W = sel_idx_w(NUM_SLAVES);

  logic [IDX_W-1:0]      r_dsel_idx;
  logic                  r_dsel_vld;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_vld;
  logic [DATA_WIDTH-1:0] w_slv_rdata;
  logic                  w_slv_ready;
  logic                  w_slv_resp;
  logic                  w_unmapped;
  logic                  w_ds_active;
  logic                  w_ds_hready;
  logic                  w_ds_hresp;

  // Descending scan so the lowest set hsel bit wins.
  always_comb begin
    w_sel_idx = '0;
    w_sel_vld = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hsel[i]) begin
        w_sel_idx = IDX_W'(i);
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_unmapped = !w_sel_vld &&
                      ((htrans_t'(htrans) == HTRANS_NONSEQ) || (htrans_t'(htrans) == HTRANS_SEQ));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_dsel_idx <= '0;
      r_dsel_vld <= 1'b0;
    end else if (hready) begin
      r_dsel_idx <= w_sel_idx;
      r_dsel_vld <= w_sel_vld;
    end
  end

  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b1;
    w_slv_resp  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dsel_idx == IDX_W'(i)) begin
        w_slv_rdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        w_slv_ready = hready_s[i];
        w_slv_resp  = hresp_s[i];
      end
    end
  end

  ahb_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .hclk         (hclk),
    .hreset       (hreset),
    .i_hready     (hready),
    .i_unmapped   (w_unmapped),
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    .i_slave_wait (r_dsel_vld && !w_slv_ready),
    .o_timeout    (timeout),
`endif
    .o_active     (w_ds_active),
    .o_hready     (w_ds_hready),
    .o_hresp      (w_ds_hresp)
  );

  // An active default slave (error or watchdog abort) overrides any selected slave.
  always_comb begin
    hrdata = '0;
    hready = w_ds_hready;
    hresp  = w_ds_hresp;
    if (r_dsel_vld && !w_ds_active) begin
      hrdata = w_slv_rdata;
      hready = w_slv_ready;
      hresp  = w_slv_resp;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios plus randomized traffic
// checked against a data-phase ownership model.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic             hclk;
  logic             hreset;
  logic [NS-1:0]    hsel;
  logic [1:0]       htrans;
  logic [NS*DW-1:0] hrdata_s;
  logic [NS-1:0]    hready_s;
  logic [NS-1:0]    hresp_s;
  logic [DW-1:0]    hrdata;
  logic             hready;
  logic             hresp;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  logic             timeout;
`endif

  int errors = 0;
  int checks = 0;

  ahb_resp_mux #(
    .NUM_SLAVES     (NS),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .hsel     (hsel),
    .htrans   (htrans),
    .hrdata_s (hrdata_s),
    .hready_s (hready_s),
    .hresp_s  (hresp_s),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp)
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Reference model: who owns the current data phase (slave index or -1 for none)
  // and which error cycle (0 none, 1 first, 2 second) the default slave is in.
  int m_owner = -1;
  int m_err   = 0;
  int m_waits = 0;
  bit m_to    = 1'b0;
  bit m_rdy;

  function automatic int lowest_sel(input logic [NS-1:0] s);
    for (int i = 0; i < NS; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic exp_ready();
    if (m_err == 1) return 1'b0;
    if (m_err == 2) return 1'b1;
    if (m_owner >= 0) return hready_s[m_owner];
    return 1'b1;
  endfunction

  function automatic logic exp_resp();
    if (m_err != 0) return 1'b1;
    if (m_owner >= 0) return hresp_s[m_owner];
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    if (m_err != 0 || m_owner < 0) return '0;
    return hrdata_s[m_owner*DW +: DW];
  endfunction

  always @(posedge hclk) begin
    m_rdy = exp_ready();
    if (hreset) begin
      m_owner = -1; m_err = 0; m_waits = 0; m_to = 1'b0;
    end else if (m_err == 1) begin
      m_err = 2;
    end else begin
      if (m_err == 0 && m_owner >= 0 && !hready_s[m_owner]) begin
        m_waits++;
        if (TIMEOUT_ON && m_waits == TO) begin
          m_err = 1; m_to = 1'b1;
        end
      end
      if (m_rdy) begin
        m_waits = 0;
        m_to    = 1'b0;
        m_owner = lowest_sel(hsel);
        m_err   = (m_owner < 0 && htrans[1]) ? 1 : 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_idle();
    hsel = '0; htrans = HTRANS_IDLE; hready_s = '1; hresp_s = '0;
  endtask

  task automatic test_reset();
    next_cycle();
    hreset = 1'b0; set_idle();
    hsel = 4'b0001; htrans = HTRANS_NONSEQ;
    next_cycle();
    hsel = '0; htrans = HTRANS_IDLE; hready_s[0] = 1'b0; hreset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      if (k == 1) hreset = 1'b0;
      @(negedge hclk);
      checks++;
      if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready[%0d]: got %b want 1", k, hready); end
      checks++;
      if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp[%0d]: got %b want 0", k, hresp); end
      checks++;
      if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata[%0d]: got %h want 0", k, hrdata); end
    end
    hready_s[0] = 1'b1;
  endtask

  task automatic test_pipeline();
    hrdata_s[0*DW +: DW] = 32'h0000_0A00;
    hrdata_s[2*DW +: DW] = 32'hCAFE_0002;
    next_cycle();
    hsel = 4'b0100; htrans = HTRANS_NONSEQ;
    next_cycle();
    hsel = 4'b0001; htrans = HTRANS_SEQ;
    @(negedge hclk);
    checks++;
    if (hrdata !== 32'hCAFE_0002) begin errors++; $display("FAIL pipe_dp1: got %h want cafe0002", hrdata); end
    checks++;
    if (hready !== 1'b1) begin errors++; $display("FAIL pipe_dp1_ready: got %b want 1", hready); end
    next_cycle();
    set_idle();
    @(negedge hclk);
    checks++;
    if (hrdata !== 32'h0000_0A00) begin errors++; $display("FAIL pipe_dp2: got %h want 00000a00", hrdata); end
  endtask

  task automatic test_wait_states();
    hrdata_s[1*DW +: DW] = 32'h1111_0001;
    hrdata_s[3*DW +: DW] = 32'h3333_0003;
    next_cycle();
    hsel = 4'b0010; htrans = HTRANS_NONSEQ;
    next_cycle();
    hsel = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      hready_s[1] = (k == 3);
      @(negedge hclk);
      checks++;
      if (hrdata !== 32'h1111_0001) begin errors++; $display("FAIL wait_data[%0d]: got %h want 11110001", k, hrdata); end
      checks++;
      if (hready !== (k == 3)) begin errors++; $display("FAIL wait_ready[%0d]: got %b want %b", k, hready, (k == 3)); end
    end
    next_cycle();
    set_idle();
    @(negedge hclk);
    checks++;
    if (hrdata !== 32'h3333_0003) begin errors++; $display("FAIL wait_switch: got %h want 33330003", hrdata); end
  endtask

  task automatic test_unmapped();
    logic [1:0] want [4];
    want = '{2'b01, 2'b11, 2'b10, 2'b10};  // {hready, hresp} per data cycle
    next_cycle();
    hsel = '0; htrans = HTRANS_NONSEQ;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      htrans = HTRANS_IDLE;
      @(negedge hclk);
      checks++;
      if ({hready, hresp} !== want[k]) begin
        errors++; $display("FAIL unmapped[%0d]: got ready/resp=%b%b want %b", k, hready, hresp, want[k]);
      end
      checks++;
      if (hrdata !== 32'h0) begin errors++; $display("FAIL unmapped_data[%0d]: got %h want 0", k, hrdata); end
    end
  endtask

  task automatic test_multi_sel();
    hrdata_s[1*DW +: DW] = 32'h6666_0001;
    hrdata_s[2*DW +: DW] = 32'h7777_0002;
    next_cycle();
    hsel = 4'b0110; htrans = HTRANS_NONSEQ;
    next_cycle();
    set_idle();
    @(negedge hclk);
    checks++;
    if (hrdata !== 32'h6666_0001) begin errors++; $display("FAIL multi_sel: got %h want 66660001", hrdata); end
    checks++;
    if (hresp !== 1'b0) begin errors++; $display("FAIL multi_sel_resp: got %b want 0", hresp); end
  endtask

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  task automatic test_timeout();
    hrdata_s[0*DW +: DW] = 32'hB00B_0000;
    next_cycle();
    hsel = 4'b1000; htrans = HTRANS_NONSEQ; hready_s[3] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      next_cycle();
      hsel = '0; htrans = HTRANS_IDLE;
      @(negedge hclk);
      checks++;
      if ({hready, hresp, timeout} !== 3'b000) begin
        errors++; $display("FAIL to_wait[%0d]: got r/e/t=%b%b%b want 000", k, hready, hresp, timeout);
      end
    end
    next_cycle();
    @(negedge hclk);
    checks++;
    if ({hready, hresp, timeout} !== 3'b011) begin
      errors++; $display("FAIL to_err1: got r/e/t=%b%b%b want 011", hready, hresp, timeout);
    end
    next_cycle();
    hsel = 4'b0001; htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    checks++;
    if ({hready, hresp, timeout} !== 3'b110) begin
      errors++; $display("FAIL to_err2: got r/e/t=%b%b%b want 110", hready, hresp, timeout);
    end
    next_cycle();
    set_idle();
    @(negedge hclk);
    checks++;
    if (hrdata !== 32'hB00B_0000 || hready !== 1'b1 || hresp !== 1'b0) begin
      errors++; $display("FAIL to_recover: got %h r=%b e=%b want b00b0000 r=1 e=0", hrdata, hready, hresp);
    end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      hreset = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 3);
      hsel = (r == 0) ? 4'b0000 : 4'($urandom);
      htrans = 2'($urandom);
      for (int i = 0; i < NS; i++) begin
        hready_s[i] = ($urandom_range(0, 3) != 0);
        hresp_s[i]  = ($urandom_range(0, 7) == 0);
        hrdata_s[i*DW +: DW] = $urandom;
      end
      @(negedge hclk);
      checks++;
      if (hready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, hready, exp_ready()); end
      checks++;
      if (hresp !== exp_resp()) begin errors++; $display("FAIL rnd_resp[%0d]: got %b want %b", n, hresp, exp_resp()); end
      checks++;
      if (hrdata !== exp_data()) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, hrdata, exp_data()); end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
      checks++;
      if (timeout !== (m_err == 1 && m_to)) begin
        errors++; $display("FAIL rnd_timeout[%0d]: got %b want %b", n, timeout, (m_err == 1 && m_to));
      end
`endif
    end
    hreset = 1'b0;
    set_idle();
  endtask

  initial begin
    hreset = 1'b1;
    hsel = '0; htrans = HTRANS_IDLE; hready_s = '1; hresp_s = '0; hrdata_s = '0;
    repeat (2) @(posedge hclk);
    test_reset();
    test_pipeline();
    test_wait_states();
    test_unmapped();
    test_multi_sel();
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule
